stack_access_sequencer: RTL
===========================

STACK_ACCESS_SEQUENCER -- requirements
Module: stack_access_sequencer

Interface
REQ-001 Parameters SHALL be: STACK_PAGE, 8'h01, high address byte of every stack access.
REQ-002 Ports SHALL be, in order:
- clk  in  1  clock, rising edge.
- nrst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  operation request.
- req_push  in  1  1 = push, 0 = pull.
- req_count  in  2  bytes to move, 1..3.
- req_data  in  24  push bytes; byte i = bits [8i+7:8i].
- req_ready  out  1  idle, request accepted this cycle if req_valid.
- sp_in  in  8  current stack pointer value.
- sp_load  out  1  one-cycle strobe; stack pointer register loads sp_load_value.
- sp_load_value  out  8  new stack pointer value.
- mem_addr  out  16  stack memory address.
- mem_we  out  1  write strobe.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  read data, valid the cycle after its address.
- done  out  1  one-cycle completion pulse.
- pull_data  out  24  pulled bytes, byte i in bits [8i+7:8i], unused bytes 0.
- wrap_err  out  1  present only with STACK_WRAP_FLAG_EN.

Function
REQ-003 The FSM SHALL have states IDLE, ACCESS, DRAIN, COMMIT.
REQ-004 IDLE: req_ready SHALL be 1. req_valid with req_count != 0 SHALL latch req_push, req_count, req_data, set the working pointer wp = sp_in and the byte index to 0, and go to ACCESS.
REQ-005 req_valid with req_count == 0 SHALL be ignored. The FSM SHALL stay in IDLE with no memory access, sp_load, or done.
REQ-006 req_ready SHALL be 0 in every state other than IDLE. req_valid outside IDLE SHALL be ignored.
REQ-007 Push ACCESS cycle: mem_addr = {STACK_PAGE, wp}, mem_we = 1, mem_wdata = byte[index]; then wp decrements and the index increments.
REQ-008 Pull ACCESS cycle: mem_addr = {STACK_PAGE, wp+1}, mem_we = 0; then wp increments. The mem_rdata sampled in the next cycle SHALL be stored into pull_data byte[index].
REQ-009 Push SHALL go ACCESS -> COMMIT after req_count access cycles.
REQ-010 Pull SHALL go ACCESS -> DRAIN -> COMMIT. DRAIN captures the last byte with mem_we = 0.
REQ-011 COMMIT: sp_load = 1, sp_load_value = wp, done = 1. The FSM SHALL return to IDLE next cycle.
REQ-012 Latency from accepting a request to done SHALL be:
- push: req_count + 1 cycles.
- pull: req_count + 2 cycles.
REQ-013 wp SHALL wrap modulo 256. The page SHALL never change.
REQ-014 mem_we SHALL be 0 outside push ACCESS cycles. mem_addr and mem_wdata SHALL be 0 in IDLE.
REQ-015 pull_data SHALL be cleared to 0 on accept and SHALL hold its value after done until the next accept.
REQ-016 sp_load and done SHALL be asserted only in COMMIT.

Reset
REQ-017 While nrst = 0, the block SHALL reset asynchronously:
- state = IDLE; wp and index = 0.
- pull_data = 0; wrap_err = 0.
- sp_load, done, mem_we = 0; mem_addr = 0.
REQ-018 Reset mid-operation SHALL abort the operation with no sp_load. After release, the block SHALL be in IDLE with req_ready = 1.

Configuration
REQ-019 With STACK_WRAP_FLAG_EN defined, wrap_err SHALL be set when:
- a push accesses wp = 8'h00, or
- a pull increments wp from 8'hFF.
REQ-020 wrap_err SHALL be sticky, SHALL be cleared on reset or on the next accepted request, and SHALL not alter sequencing.
REQ-021 Without STACK_WRAP_FLAG_EN, the wrap_err port and its logic SHALL be absent. All other behaviour SHALL be identical.

Verification
REQ-022 Push 2, sp_in = 8'hFD, req_data = 24'h00_34_12 -> write 8'h12 @16'h01FD, write 8'h34 @16'h01FC, then sp_load_value = 8'hFB with done 3 cycles after accept.
REQ-023 Pull 3, sp_in = 8'hFA, memory 01FB/01FC/01FD = 8'hAA/8'hBB/8'hCC -> pull_data = 24'hCC_BB_AA, sp_load_value = 8'hFD, done 5 cycles after accept.
REQ-024 Push 1 with sp_in = 8'h00 -> write @16'h0100, sp_load_value = 8'hFF; wrap_err = 1 when the macro is defined.
REQ-025 Each case below -> no state change, no mem_we, no done:
- req_count = 0 in IDLE;
- req_valid asserted during ACCESS.
REQ-026 nrst pulsed low during the second ACCESS of a push 3 -> no sp_load, outputs at reset values; a following pull 1 completes normally.

Source files
------------

// File: rtl/stack_access_sequencer.sv
// Stack push/pull sequencer: moves 1..3 bytes between a request and the stack page,
// then loads the updated stack pointer. Optional wrap flag under STACK_WRAP_FLAG_EN.
module stack_access_sequencer #(
    parameter logic [7:0] STACK_PAGE = 8'h01
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        req_valid,
    input  logic        req_push,
    input  logic [1:0]  req_count,
    input  logic [23:0] req_data,
    output logic        req_ready,
    input  logic [7:0]  sp_in,
    output logic        sp_load,
    output logic [7:0]  sp_load_value,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        done,
    output logic [23:0] pull_data
`ifdef STACK_WRAP_FLAG_EN
    ,
    output logic        wrap_err
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, COMMIT} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_push;
    logic [1:0]  r_count;
    logic [23:0] r_data;
    logic [7:0]  r_wp;
    logic [1:0]  r_idx;
    logic        r_cap_valid;
    logic [1:0]  r_cap_idx;
    logic [23:0] r_pull_data;
    logic        w_accept;
    logic        w_last;
    logic [7:0]  w_wp_inc;

    assign w_wp_inc      = r_wp + 8'd1;
    assign w_last        = (r_idx == (r_count - 2'd1));
    assign sp_load_value = r_wp;
    assign pull_data     = r_pull_data;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        req_ready    = 1'b0;
        mem_addr     = 16'h0000;
        mem_we       = 1'b0;
        mem_wdata    = 8'h00;
        sp_load      = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && (req_count != 2'd0)) begin
                    w_accept     = 1'b1;
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                // Push writes at wp then moves down; pull reads above wp then moves up.
                if (r_push) begin
                    mem_addr  = {STACK_PAGE, r_wp};
                    mem_we    = 1'b1;
                    mem_wdata = r_data[{r_idx, 3'b000} +: 8];
                end else begin
                    mem_addr = {STACK_PAGE, w_wp_inc};
                end
                if (w_last) begin
                    w_next_state = r_push ? COMMIT : DRAIN;
                end
            end
            DRAIN: begin
                w_next_state = COMMIT;
            end
            COMMIT: begin
                sp_load      = 1'b1;
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_push      <= 1'b0;
            r_count     <= 2'd0;
            r_data      <= 24'h0;
            r_wp        <= 8'h00;
            r_idx       <= 2'd0;
            r_cap_valid <= 1'b0;
            r_cap_idx   <= 2'd0;
            r_pull_data <= 24'h0;
        end else begin
            r_cap_valid <= 1'b0;
            // Read data arrives one cycle after its address; store it into the byte it was issued for.
            if (r_cap_valid) begin
                r_pull_data[{r_cap_idx, 3'b000} +: 8] <= mem_rdata;
            end
            if (w_accept) begin
                r_push      <= req_push;
                r_count     <= req_count;
                r_data      <= req_data;
                r_wp        <= sp_in;
                r_idx       <= 2'd0;
                r_pull_data <= 24'h0;
            end else if (r_state == ACCESS) begin
                r_idx <= r_idx + 2'd1;
                if (r_push) begin
                    r_wp <= r_wp - 8'd1;
                end else begin
                    r_wp        <= w_wp_inc;
                    r_cap_valid <= 1'b1;
                    r_cap_idx   <= r_idx;
                end
            end
        end
    end

`ifdef STACK_WRAP_FLAG_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wrap_err <= 1'b0;
        end else if (w_accept) begin
            wrap_err <= 1'b0;
        end else if (r_state == ACCESS) begin
            if ((r_push && (r_wp == 8'h00)) || (!r_push && (r_wp == 8'hFF))) begin
                wrap_err <= 1'b1;
            end
        end
    end
`endif

endmodule
